// File: rtl/ct_f_spsram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ct_f_spsram_ctrl
// Description : Two-port round-robin front end for a single-port SRAM with a
//               post-reset zero-fill sequence and one-cycle read return.
// Revision    : 1.0 - initial release
// ============================================================================
module ct_f_spsram_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 144,
    parameter int INIT_EN    = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  p0_req,
    input  logic                  p0_wr,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    input  logic [DATA_WIDTH-1:0] p0_wmask,
    output logic                  p0_gnt,
    input  logic                  p1_req,
    input  logic                  p1_wr,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    input  logic [DATA_WIDTH-1:0] p1_wmask,
    output logic                  p1_gnt,
    output logic                  rd_vld,
    output logic                  rd_id,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t c_RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;
    localparam logic [ADDR_WIDTH-1:0] c_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_init_cnt;
    logic                    r_init_done;
    logic                    r_prio;      // 0: p0 wins a tie, 1: p1 wins a tie
    logic                    r_rd_vld;
    logic                    r_rd_id;
    logic                    w_g0;
    logic                    w_g1;
    logic                    w_rd_gnt;

    // State register; reset lands in INIT only when the zero-fill is enabled
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= c_RST_STATE;
        else     r_state <= w_state_nxt;
    end

    // Leave INIT right after the last address has been written
    always_comb begin
        w_state_nxt = r_state;
        if ((r_state == ST_INIT) && (r_init_cnt == {ADDR_WIDTH{1'b1}}))
            w_state_nxt = ST_RUN;
    end

    // Fill address counter, advances once per INIT cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                    r_init_cnt <= '0;
        else if (r_state == ST_INIT) r_init_cnt <= r_init_cnt + c_ONE;
    end

    // Registered ready flag; also gates grants so nothing is granted while
    // reset is held, even when reset enters RUN directly
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_init_done <= 1'b0;
        else     r_init_done <= (w_state_nxt == ST_RUN);
    end

    // Round-robin grant: a lone request wins, a tie goes to the prioritised side
    always_comb begin
        w_g0     = r_init_done && p0_req && (!p1_req || !r_prio);
        w_g1     = r_init_done && p1_req && (!p0_req ||  r_prio);
        w_rd_gnt = (w_g0 && !p0_wr) || (w_g1 && !p1_wr);
    end

    // Priority moves to the other requester after each grant
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)       r_prio <= 1'b0;
        else if (w_g0) r_prio <= 1'b1;
        else if (w_g1) r_prio <= 1'b0;
    end

    // SRAM drive: idle in reset, zero-fill in INIT, granted access in RUN
    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_d    = '0;
        sram_a    = '0;
        if (RST) begin
            sram_cen = 1'b1;
        end else if (r_state == ST_INIT) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = r_init_cnt;
        end else if (w_g0) begin
            sram_cen = 1'b0;
            sram_a   = p0_addr;
            if (p0_wr) begin
                sram_gwen = 1'b0;
                sram_wen  = ~p0_wmask;
                sram_d    = p0_wdata;
            end
        end else if (w_g1) begin
            sram_cen = 1'b0;
            sram_a   = p1_addr;
            if (p1_wr) begin
                sram_gwen = 1'b0;
                sram_wen  = ~p1_wmask;
                sram_d    = p1_wdata;
            end
        end
    end

    // Read return tracking: valid and owner one cycle after a read grant
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rd_vld <= 1'b0;
            r_rd_id  <= 1'b0;
        end else begin
            r_rd_vld <= w_rd_gnt;
            if (w_rd_gnt) r_rd_id <= w_g1;
        end
    end

    // Output mapping; read data is forced to zero when not valid
    always_comb begin
        p0_gnt    = w_g0;
        p1_gnt    = w_g1;
        init_done = r_init_done;
        rd_vld    = r_rd_vld;
        rd_id     = r_rd_id;
        rd_data   = r_rd_vld ? sram_q : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_ct_f_spsram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ct_f_spsram_ctrl
// Description : Scoreboard bench for ct_f_spsram_ctrl with an SRAM model,
//               a word-level reference memory and a round-robin model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ct_f_spsram_ctrl;

    localparam int AW = 12;
    localparam int DW = 144;
    localparam int DEPTH = 4096;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          RST2 = 1'b1;

    logic          p0_req = 0, p0_wr = 0, p1_req = 0, p1_wr = 0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_wdata = '0, p0_wmask = '0, p1_wdata = '0, p1_wmask = '0;
    logic          p0_gnt, p1_gnt, rd_vld, rd_id, init_done;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] sram_a;
    logic          sram_cen, sram_gwen;
    logic [DW-1:0] sram_wen, sram_d;
    logic [DW-1:0] sram_q = '0;

    // second instance with the zero-fill disabled
    logic          q_req = 0;
    logic [AW-1:0] q_addr = 12'h03C;
    logic          q_p0_gnt, q_p1_gnt, q_rd_vld, q_rd_id, q_init_done;
    logic [DW-1:0] q_rd_data;
    logic [AW-1:0] q_sram_a;
    logic          q_sram_cen, q_sram_gwen;
    logic [DW-1:0] q_sram_wen, q_sram_d;
    logic [DW-1:0] q_sram_q = {9{16'hC35A}};

    int n_checks = 0;
    int n_err    = 0;

    always #5 CLK = ~CLK;

    ct_f_spsram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_EN(1)) u_dut (
        .CLK(CLK), .RST(RST),
        .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_wmask(p0_wmask), .p0_gnt(p0_gnt),
        .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_wmask(p1_wmask), .p1_gnt(p1_gnt),
        .rd_vld(rd_vld), .rd_id(rd_id), .rd_data(rd_data), .init_done(init_done),
        .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
        .sram_wen(sram_wen), .sram_d(sram_d), .sram_q(sram_q)
    );

    ct_f_spsram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_EN(0)) u_dut_nofill (
        .CLK(CLK), .RST(RST2),
        .p0_req(1'b0), .p0_wr(1'b0), .p0_addr('0), .p0_wdata('0),
        .p0_wmask('0), .p0_gnt(q_p0_gnt),
        .p1_req(q_req), .p1_wr(1'b0), .p1_addr(q_addr), .p1_wdata('0),
        .p1_wmask('0), .p1_gnt(q_p1_gnt),
        .rd_vld(q_rd_vld), .rd_id(q_rd_id), .rd_data(q_rd_data), .init_done(q_init_done),
        .sram_a(q_sram_a), .sram_cen(q_sram_cen), .sram_gwen(q_sram_gwen),
        .sram_wen(q_sram_wen), .sram_d(q_sram_d), .sram_q(q_sram_q)
    );

    // Behavioural single-port SRAM with bit write enables
    logic [DW-1:0] sram_mem [DEPTH];
    always @(posedge CLK) begin
        if (!sram_cen) begin
            if (!sram_gwen)
                sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else
                sram_q <= sram_mem[sram_a];
        end
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: word memory, last-granted requester, expectations
    // ------------------------------------------------------------------
    typedef struct {
        int            due;
        logic          id;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           rdq[$];
    logic [DW-1:0] ref_mem [DEPTH];
    logic          last_granted = 1'b1;   // nobody granted yet: p0 goes first
    int            cyc = 0;
    logic          mon_en = 1'b0;
    logic          exp_g0, exp_g1, exp_cen, exp_gwen;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_wen, exp_d;

    task automatic issue(input logic r0, input logic w0, input logic [AW-1:0] a0,
                         input logic [DW-1:0] d0, input logic [DW-1:0] m0,
                         input logic r1, input logic w1, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d1, input logic [DW-1:0] m1);
        logic          g0, g1, wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d, m;
        @(posedge CLK);
        #1;
        p0_req = r0; p0_wr = w0; p0_addr = a0; p0_wdata = d0; p0_wmask = m0;
        p1_req = r1; p1_wr = w1; p1_addr = a1; p1_wdata = d1; p1_wmask = m1;
        cyc++;
        mon_en = 1'b1;
        if (r0 && r1) begin
            g0 = (last_granted == 1'b1);
            g1 = !g0;
        end else begin
            g0 = r0;
            g1 = r1;
        end
        if (g0) last_granted = 1'b0;
        if (g1) last_granted = 1'b1;
        wr = g1 ? w1 : w0;
        a  = g1 ? a1 : a0;
        d  = g1 ? d1 : d0;
        m  = g1 ? m1 : m0;
        exp_g0   = g0;
        exp_g1   = g1;
        exp_cen  = !(g0 || g1);
        exp_a    = (g0 || g1) ? a : '0;
        exp_gwen = !((g0 || g1) && wr);
        exp_wen  = ((g0 || g1) && wr) ? ~m : '1;
        exp_d    = ((g0 || g1) && wr) ? d : '0;
        if ((g0 || g1) && wr)
            ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
        if ((g0 || g1) && !wr)
            rdq.push_back('{cyc + 1, g1, ref_mem[a]});
    endtask

    task automatic idle();
        issue(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] v;
        v = '0;
        for (int k = 0; k < 5; k++) v = {v[DW-33:0], 32'($urandom())};
        return v;
    endfunction

    // Monitor: compares the DUT against the expectations of the current cycle
    always @(negedge CLK) begin
        if (mon_en) begin
            rd_t e;
            chk1("init_done_run", init_done, 1'b1);
            chk1("p0_gnt", p0_gnt, exp_g0);
            chk1("p1_gnt", p1_gnt, exp_g1);
            chk1("sram_cen", sram_cen, exp_cen);
            chk1("sram_gwen", sram_gwen, exp_gwen);
            chka("sram_a", sram_a, exp_a);
            chkd("sram_wen", sram_wen, exp_wen);
            chkd("sram_d", sram_d, exp_d);
            if (rdq.size() > 0 && rdq[0].due == cyc) begin
                e = rdq.pop_front();
                chk1("rd_vld", rd_vld, 1'b1);
                chk1("rd_id", rd_id, e.id);
                chkd("rd_data", rd_data, e.data);
            end else begin
                chk1("rd_vld_idle", rd_vld, 1'b0);
                chkd("rd_data_idle", rd_data, '0);
            end
        end
    end

    initial begin
        int            good;
        logic [AW-1:0] ea;
        logic [DW-1:0] ones;
        ones = '1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        // requests held throughout reset and the fill; they must wait
        p0_req = 1'b1; p0_addr = 12'h005;
        p1_req = 1'b1; p1_addr = 12'h006;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk1("rst_init_done", init_done, 1'b0);
        chk1("rst_rd_vld", rd_vld, 1'b0);
        chk1("rst_rd_id", rd_id, 1'b0);
        chkd("rst_rd_data", rd_data, '0);
        chk1("rst_p0_gnt", p0_gnt, 1'b0);
        chk1("rst_p1_gnt", p1_gnt, 1'b0);
        chk1("rst_sram_cen", sram_cen, 1'b1);
        chk1("rst_sram_gwen", sram_gwen, 1'b1);
        chkd("rst_sram_wen", sram_wen, ones);
        chkd("rst_sram_d", sram_d, '0);
        chka("rst_sram_a", sram_a, '0);
        chk1("nf_rst_init_done", q_init_done, 1'b0);
        chk1("nf_rst_p1_gnt", q_p1_gnt, 1'b0);
        chk1("nf_rst_sram_cen", q_sram_cen, 1'b1);
        chkd("nf_rst_sram_wen", q_sram_wen, ones);
        chkd("nf_rst_sram_d", q_sram_d, '0);

        // partial fill up to address 2000, then reset again
        @(posedge CLK); #1; RST = 1'b0;
        good = 0; ea = '0;
        for (int i = 0; i <= 2000; i++) begin
            @(negedge CLK);
            if (sram_a == ea && !sram_cen && !sram_gwen && !p0_gnt && !p1_gnt) good++;
            ea = ea + 12'd1;
        end
        chki("partial_fill", good, 2001);
        @(posedge CLK); #1; RST = 1'b1;
        @(negedge CLK);
        chk1("midfill_rst_init_done", init_done, 1'b0);
        chk1("midfill_rst_cen", sram_cen, 1'b1);

        // complete fill from address 0
        @(posedge CLK); #1; RST = 1'b0;
        good = 0; ea = '0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge CLK);
            if (sram_a == ea && !sram_cen && !sram_gwen && sram_wen == '0 && sram_d == '0
                && !p0_gnt && !p1_gnt && !init_done) good++;
            ea = ea + 12'd1;
        end
        chki("full_fill", good, DEPTH);

        // held requests: both pending, first RUN cycle onwards alternates p0,p1,p0,p1
        for (int i = 0; i < 4; i++)
            issue(1'b1, 1'b0, 12'h005, '0, '0, 1'b1, 1'b0, 12'h006, '0, '0);

        // full-mask write then read back
        issue(1'b1, 1'b1, 12'h010, {18{8'hA5}}, ones, 1'b0, 1'b0, '0, '0, '0);
        issue(1'b1, 1'b0, 12'h010, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        // zero-mask write leaves the word unchanged
        issue(1'b1, 1'b1, 12'h010, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        issue(1'b1, 1'b0, 12'h010, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        // partial mask on a zeroed word
        issue(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1, 12'h020, ones, 144'hFF);
        issue(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 12'h020, '0, '0);
        idle();

        // randomized traffic on a small address window for frequent hits
        for (int i = 0; i < 400; i++) begin
            logic [DW-1:0] m0, m1;
            m0 = rand_word();
            m1 = rand_word();
            if ($urandom_range(0, 7) == 0) m0 = '0;
            if ($urandom_range(0, 7) == 1) m1 = ones;
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  12'($urandom_range(0, 15)), rand_word(), m0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  12'($urandom_range(0, 15)), rand_word(), m1);
        end
        idle();
        idle();
        chki("scoreboard_drained", rdq.size(), 0);

        // reset in the cycle after a read grant kills the pending return
        issue(1'b1, 1'b0, 12'h010, '0, '0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge CLK); #1; mon_en = 1'b0;
        @(posedge CLK); #1; RST = 1'b1; p0_req = 1'b0;
        @(negedge CLK);
        chk1("rst_after_rd_vld", rd_vld, 1'b0);
        chkd("rst_after_rd_data", rd_data, '0);
        chk1("rst_after_init_done", init_done, 1'b0);
        rdq.delete();

        // no-fill instance: ready on first edge, p1 read returns a cycle later
        q_req = 1'b1;
        @(posedge CLK); #1; RST2 = 1'b0;
        @(negedge CLK);
        chk1("nf_pre_edge_init_done", q_init_done, 1'b0);
        chk1("nf_pre_edge_p1_gnt", q_p1_gnt, 1'b0);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk1("nf_init_done", q_init_done, 1'b1);
        chk1("nf_p1_gnt", q_p1_gnt, 1'b1);
        chk1("nf_p0_gnt", q_p0_gnt, 1'b0);
        chk1("nf_sram_cen", q_sram_cen, 1'b0);
        chk1("nf_sram_gwen", q_sram_gwen, 1'b1);
        chka("nf_sram_a", q_sram_a, 12'h03C);
        @(posedge CLK); #1; q_req = 1'b0;
        @(negedge CLK);
        chk1("nf_rd_vld", q_rd_vld, 1'b1);
        chk1("nf_rd_id", q_rd_id, 1'b1);
        chkd("nf_rd_data", q_rd_data, {9{16'hC35A}});

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ct_f_spsram_ctrl.md
CT_F_SPSRAM_CTRL -- requirements
Module: ct_f_spsram_ctrl

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- ADDR_WIDTH, 12, SRAM address width (4096 entries).
- DATA_WIDTH, 144, SRAM word width.
- INIT_EN, 1, 1 = zero-fill the whole SRAM after reset; 0 = skip the fill.

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- CLK, in, 1, single clock for all state.
- RST, in, 1, asynchronous, active-high reset.
- pN_req, in, 1, requester N (N=0,1) access request.
- pN_wr, in, 1, 1 = write, 0 = read.
- pN_addr, in, ADDR_WIDTH, access address.
- pN_wdata, in, DATA_WIDTH, write data.
- pN_wmask, in, DATA_WIDTH, active-high per-bit write enable.
- pN_gnt, out, 1, request accepted this cycle.
- rd_vld, out, 1, read data valid.
- rd_id, out, 1, requester that owns rd_data.
- rd_data, out, DATA_WIDTH, read data.
- init_done, out, 1, SRAM is ready for requester traffic.
- sram_a, out, ADDR_WIDTH, SRAM address.
- sram_cen, out, 1, SRAM chip enable, active-low.
- sram_gwen, out, 1, SRAM global write enable, active-low.
- sram_wen, out, DATA_WIDTH, SRAM bit write enables, active-low.
- sram_d, out, DATA_WIDTH, SRAM write data.
- sram_q, in, DATA_WIDTH, SRAM read data; valid the cycle after a read access, then held while sram_cen=1.

REQ-003 Reset SHALL be asynchronous and active-high on RST, and the block SHALL use one clock, CLK.

Function
REQ-004 The FSM SHALL have two states, INIT and RUN; reset SHALL enter INIT if INIT_EN=1 and RUN otherwise.

REQ-005 In INIT, every cycle SHALL drive the following, with the counter starting at 0 and incrementing by 1 per cycle:
- sram_cen=0, sram_gwen=0, sram_wen=all 0, sram_d=0, sram_a=init counter.

REQ-006 After the write to address 2^ADDR_WIDTH-1, the FSM SHALL move to RUN on the next edge (4096 fill cycles at default).

REQ-007 init_done SHALL be 1 exactly when the FSM is in RUN, and SHALL be registered.

REQ-008 In INIT, p0_gnt and p1_gnt SHALL be 0 and requests SHALL be ignored without loss (requesters hold req).

REQ-009 In RUN, at most one grant SHALL be asserted per cycle, combinationally from the req inputs and the round-robin pointer.

REQ-010 Round-robin arbitration in RUN:
- Exactly one req: that requester is granted.
- Both req: the requester not granted most recently is granted.
- The pointer updates only on a grant.
- The reset pointer favours p0.

REQ-011 A grant SHALL drive the SRAM in the same cycle as follows:
- sram_cen=0, sram_a=pN_addr.
- Write: sram_gwen=0, sram_wen=~pN_wmask, sram_d=pN_wdata.
- Read: sram_gwen=1, sram_wen=all 1.

REQ-012 With no grant in RUN, the SRAM outputs SHALL be: sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_d=0, sram_a=0.

REQ-013 A granted read SHALL produce, one cycle later: rd_vld=1, rd_id=granted N, rd_data=sram_q.

REQ-014 rd_data SHALL be 0 whenever rd_vld=0; granted writes SHALL produce no rd_vld.

REQ-015 Back-to-back grants SHALL be accepted every cycle, with full throughput and no bubbles between reads, writes or requesters.

REQ-016 A write with pN_wmask=0 SHALL still be granted and SHALL modify no bits.

REQ-017 Read-after-write to the same address in consecutive cycles SHALL return the written data, since the SRAM access is serialized.

Reset
REQ-018 The following outputs SHALL take these values while RST=1:
- init_done=0, rd_vld=0, rd_id=0, rd_data=0, p0_gnt=0, p1_gnt=0.
- sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_d=0, sram_a=0.

REQ-019 On reset, the init counter and the round-robin pointer (p0 favoured) SHALL be cleared.

REQ-020 RST asserted mid-INIT SHALL restart the fill at address 0.

REQ-021 RST asserted in the cycle after a read grant SHALL suppress rd_vld.

Verification
REQ-022 Reset release, INIT_EN=1 -> 4096 consecutive cycles with sram_cen=0, sram_gwen=0, sram_a=0..4095; init_done=1 on the following edge; no gnt during the fill.

REQ-023 In RUN, p0 write addr 0x010, data 0xA5..A5, wmask all 1, then p0 read 0x010 -> sram_wen=all 0 on the write; rd_vld=1, rd_id=0, rd_data=0xA5..A5 one cycle after the read grant.

REQ-024 p0_req=p1_req=1 held for 4 cycles from reset pointer -> grants p0,p1,p0,p1; sram_cen=0 on all 4 cycles.

REQ-025 Write with wmask=0x0..0FF to a zeroed word with data all 1, then read -> rd_data=0x0..0FF.

REQ-026 RST pulsed at init address 2000 -> init_done=0, fill restarts at sram_a=0 and completes after a further 4096 cycles.

REQ-027 INIT_EN=0 -> init_done=1 on the first edge after reset release; a p1 read granted in that cycle returns rd_vld, rd_id=1 on the next cycle.
